riscv_data_mem_responder: RTL

- Responder (memory side) for the core's load/store request interface. A core or bus master issues a request; this block services it with RISC-V byte, halfword and word semantics, then returns a response.
- Holds a word-addressed data RAM of NUM_MEM_LOCS words. Adds a configurable wait-state latency so that the core's stall logic can be exercised.
- Handles one outstanding transaction at a time, using a valid/ready handshake on both the request and response channels.

---
 rtl/riscv_data_mem_responder_if.sv | 26 ++
 rtl/riscv_data_mem_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv_data_mem_responder_if.sv
// Load/store request and response channels between a core (master) and the
// data memory responder (slave).
interface riscv_data_mem_responder_if #(
    parameter int REG_WIDTH = 32
);
    logic                 req_valid;
    logic                 req_ready;
    logic                 req_we;
    logic [REG_WIDTH-1:0] req_addr;
    logic [2:0]           req_funct3;
    logic [REG_WIDTH-1:0] req_wdata;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [REG_WIDTH-1:0] rsp_rdata;
    logic                 rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_funct3, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/riscv_data_mem_responder.sv
// Word-addressed data RAM answering RISC-V B/H/W loads and stores after LATENCY wait cycles.
// Define DMEM_ERR_CHECK_EN to flag misaligned, out-of-range and illegal-funct3 accesses.
module riscv_data_mem_responder #(
    parameter int REG_WIDTH    = 32,
    parameter int NUM_MEM_LOCS = 64,
    parameter int LATENCY      = 1
) (
    input  logic                   clk,
    input  logic                   rstn,
    riscv_data_mem_responder_if.slave bus,
    output logic [REG_WIDTH-1:0]   mem1,
    output logic [1:0]             dbg_state
);
    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; once raised, valid and its payload hold until that edge.
    localparam int IDX_W = (NUM_MEM_LOCS > 1) ? $clog2(NUM_MEM_LOCS) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } size_t;

    state_t               state_q;
    logic [3:0]           cnt_q;
    logic                 we_q;
    logic [REG_WIDTH-1:0] addr_q;
    logic [2:0]           f3_q;
    logic [REG_WIDTH-1:0] wdata_q;
    logic                 rsp_valid_q;
    logic [REG_WIDTH-1:0] rsp_rdata_q;
    logic                 rsp_err_q;
    logic [REG_WIDTH-1:0] mem_q [NUM_MEM_LOCS];

    // With LATENCY=0 the commit happens on the acceptance edge, so the
    // datapath must look at the live request instead of the latched copy.
    logic                 c_we;
    logic [REG_WIDTH-1:0] c_addr;
    logic [REG_WIDTH-1:0] c_wdata;
    logic [2:0]           c_f3;
    logic [29:0]          c_word;
    logic [IDX_W-1:0]     c_idx;
    logic [1:0]           c_lane;
    logic [1:0]           eff_lane;
    logic [REG_WIDTH-1:0] rd_word;
    size_t                sz;
    logic                 uns;
    logic                 f3_bad;
    logic                 c_err;
    logic [7:0]           byte_sel;
    logic [15:0]          half_sel;
    logic [REG_WIDTH-1:0] load_val;
    logic [3:0]           st_mask;
    logic [REG_WIDTH-1:0] st_data;
    logic [REG_WIDTH-1:0] wr_word;
    logic                 commit;

    assign c_we    = (state_q == S_IDLE) ? bus.req_we     : we_q;
    assign c_addr  = (state_q == S_IDLE) ? bus.req_addr   : addr_q;
    assign c_wdata = (state_q == S_IDLE) ? bus.req_wdata  : wdata_q;
    assign c_f3    = (state_q == S_IDLE) ? bus.req_funct3 : f3_q;

    assign c_word  = c_addr[31:2];
    assign c_idx   = c_word[IDX_W-1:0];
    assign c_lane  = c_addr[1:0];
    assign rd_word = mem_q[c_idx];

    always_comb begin
        sz     = SZ_W;
        uns    = 1'b0;
        f3_bad = 1'b0;
        case (c_f3)
            3'b000: sz = SZ_B;
            3'b001: sz = SZ_H;
            3'b010: sz = SZ_W;
            3'b100: begin
                if (c_we) begin
                    f3_bad = 1'b1;
                end else begin
                    sz  = SZ_B;
                    uns = 1'b1;
                end
            end
            3'b101: begin
                if (c_we) begin
                    f3_bad = 1'b1;
                end else begin
                    sz  = SZ_H;
                    uns = 1'b1;
                end
            end
            default: f3_bad = 1'b1;
        endcase
    end

    // Halves ignore addr[0] and words ignore addr[1:0]; only matters when unchecked.
    assign eff_lane = (sz == SZ_W) ? 2'b00 :
                      (sz == SZ_H) ? {c_lane[1], 1'b0} : c_lane;

`ifdef DMEM_ERR_CHECK_EN
    assign c_err = f3_bad
                 || ((sz == SZ_H) && c_lane[0])
                 || ((sz == SZ_W) && (c_lane != 2'b00))
                 || ({2'b00, c_word} >= 32'(NUM_MEM_LOCS));
`else
    logic unused_bits;
    assign unused_bits = ^{f3_bad, c_word[29:IDX_W]};
    assign c_err       = 1'b0;
`endif

    assign byte_sel = rd_word[{eff_lane, 3'b000} +: 8];
    assign half_sel = eff_lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_val = rd_word;
        st_mask  = 4'b1111;
        st_data  = c_wdata;
        case (sz)
            SZ_B: begin
                load_val = uns ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
                st_mask  = 4'b0001 << eff_lane;
                st_data  = {4{c_wdata[7:0]}};
            end
            SZ_H: begin
                load_val = uns ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
                st_mask  = eff_lane[1] ? 4'b1100 : 4'b0011;
                st_data  = {2{c_wdata[15:0]}};
            end
            default: begin
                load_val = rd_word;
                st_mask  = 4'b1111;
                st_data  = c_wdata;
            end
        endcase
    end

    always_comb begin
        wr_word = rd_word;
        for (int i = 0; i < 4; i++) begin
            if (st_mask[i]) wr_word[8*i +: 8] = st_data[8*i +: 8];
        end
    end

    assign commit = ((state_q == S_IDLE) && bus.req_valid && (LATENCY == 0))
                 || ((state_q == S_WAIT) && (cnt_q == 4'd0));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            f3_q        <= 3'b000;
            wdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            for (int i = 0; i < NUM_MEM_LOCS; i++) mem_q[i] <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        addr_q  <= bus.req_addr;
                        f3_q    <= bus.req_funct3;
                        wdata_q <= bus.req_wdata;
                        if (LATENCY == 0) begin
                            state_q <= S_RESP;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= 4'(LATENCY - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) state_q <= S_RESP;
                    else               cnt_q   <= cnt_q - 4'd1;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            if (commit) begin
                rsp_valid_q <= 1'b1;
                rsp_err_q   <= c_err;
                rsp_rdata_q <= (c_we || c_err) ? '0 : load_val;
                if (c_we && !c_err) mem_q[c_idx] <= wr_word;
            end
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign mem1          = mem_q[1];
    assign dbg_state     = state_q;
endmodule
